// File: rtl/uart_report_defs.sv
// ------------------------------------------------------------------------------------------
// uart_report_defs: shared types, character codes and line-format helpers for mw_status_tx.
// Rev 1.0
// ------------------------------------------------------------------------------------------
`default_nettype none

package uart_report_defs;

  typedef enum logic [1:0] {
    SEQ_IDLE   = 2'd0,
    SEQ_LOAD   = 2'd1,
    SEQ_WAIT   = 2'd2,
    SEQ_FINISH = 2'd3
  } seq_state_t;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_LF    = 8'h0A;
  localparam logic [7:0] CHAR_0     = 8'h30;
  localparam logic [7:0] CHAR_A     = 8'h41;

  // Five register fields, then ZF, ZAK, CR, LF.
  localparam int NUM_REGS   = 5;
  localparam int TAIL_CHARS = 4;

  function automatic int line_length(input int hex_digits);
    return NUM_REGS * (hex_digits + 1) + TAIL_CHARS;
  endfunction

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return CHAR_0 + {4'd0, nib};
    end
    return CHAR_A + {4'd0, nib} - 8'd10;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx.sv
// ------------------------------------------------------------------------------------------
// uart_tx: 8N1 byte serializer with a valid/ready handshake; ready also in last stop cycle.
// Rev 1.0
// ------------------------------------------------------------------------------------------
`default_nettype none

module uart_tx
  import uart_report_defs::*;
#(
  parameter int CLKS_PER_BIT = 234
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       txd
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             bit_end;

  assign bit_end  = (cnt == CNT_LAST);
  // Accepting during the final stop cycle lets frames run with no idle gap.
  assign tx_ready = (state == TX_IDLE) || ((state == TX_STOP) && bit_end);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= TX_IDLE;
      cnt     <= '0;
      bit_idx <= 3'd0;
      shift   <= 8'd0;
      txd     <= 1'b1;
    end else if (tx_valid && tx_ready) begin
      state   <= TX_START;
      cnt     <= '0;
      bit_idx <= 3'd0;
      shift   <= tx_data;
      txd     <= 1'b0;
    end else begin
      case (state)
        TX_IDLE: begin
          cnt <= '0;
          txd <= 1'b1;
        end
        TX_START: begin
          if (bit_end) begin
            cnt   <= '0;
            state <= TX_DATA;
            txd   <= shift[0];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= TX_STOP;
              txd   <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              txd     <= shift[1];
              shift   <= {1'b0, shift[7:1]};
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (bit_end) begin
            cnt   <= '0;
            state <= TX_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/mw_status_tx.sv
// ------------------------------------------------------------------------------------------
// mw_status_tx: on trigger, snapshot core registers/flags and send them as one ASCII hex line.
// Rev 1.0
// ------------------------------------------------------------------------------------------
`default_nettype none

module mw_status_tx
  import uart_report_defs::*;
#(
  parameter int CLK_HZ     = 27_000_000,
  parameter int BIT_RATE   = 115_200,
  parameter int HEX_DIGITS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trigger,
  input  logic [63:0] L,
  input  logic [63:0] I,
  input  logic [63:0] A,
  input  logic [63:0] S,
  input  logic [63:0] Ak,
  input  logic        ZF,
  input  logic        ZAK,
  output logic        uart_tx,
  output logic        busy,
  output logic        done,
  output logic        overrun
);

  localparam int CLKS_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int LINE_LEN     = line_length(HEX_DIGITS);
  localparam int FIELD_LEN    = HEX_DIGITS + 1;
  localparam int REG_CHARS    = NUM_REGS * FIELD_LEN;
  localparam logic [6:0] LAST_IDX = 7'(LINE_LEN - 1);

  seq_state_t  state;
  logic [6:0]  idx;
  logic [63:0] snap [NUM_REGS];
  logic        zf_q;
  logic        zak_q;

  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  tx_char;
  logic [2:0]  fld;
  logic [4:0]  pos;

  assign tx_valid = (state == SEQ_LOAD) || (state == SEQ_WAIT);

  // Character index -> (field, position); the space closes each register field.
  always_comb begin
    tx_char = CHAR_LF;
    fld     = 3'(int'(idx) / FIELD_LEN);
    pos     = 5'(int'(idx) % FIELD_LEN);
    if (int'(idx) < REG_CHARS) begin
      if (int'(pos) == HEX_DIGITS) begin
        tx_char = CHAR_SPACE;
      end else begin
        tx_char = hex_ascii(4'(snap[fld] >> (4 * (HEX_DIGITS - 1 - int'(pos)))));
      end
    end else if (int'(idx) == REG_CHARS) begin
      tx_char = CHAR_0 | {7'd0, zf_q};
    end else if (int'(idx) == REG_CHARS + 1) begin
      tx_char = CHAR_0 | {7'd0, zak_q};
    end else if (int'(idx) == REG_CHARS + 2) begin
      tx_char = CHAR_CR;
    end
  end

  uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clk     (clk),
    .reset   (reset),
    .tx_valid(tx_valid),
    .tx_data (tx_char),
    .tx_ready(tx_ready),
    .txd     (uart_tx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= SEQ_IDLE;
      idx     <= 7'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      overrun <= 1'b0;
      zf_q    <= 1'b0;
      zak_q   <= 1'b0;
      for (int k = 0; k < NUM_REGS; k++) begin
        snap[k] <= 64'd0;
      end
    end else begin
      done    <= 1'b0;
      // The done cycle still counts as busy, so a trigger there is dropped.
      overrun <= trigger && (busy || done);
      case (state)
        SEQ_IDLE: begin
          if (trigger && !done) begin
            snap[0] <= L;
            snap[1] <= I;
            snap[2] <= A;
            snap[3] <= S;
            snap[4] <= Ak;
            zf_q    <= ZF;
            zak_q   <= ZAK;
            idx     <= 7'd0;
            busy    <= 1'b1;
            state   <= SEQ_LOAD;
          end
        end
        SEQ_LOAD, SEQ_WAIT: begin
          if (tx_ready) begin
            if (idx == LAST_IDX) begin
              state <= SEQ_FINISH;
            end else begin
              idx   <= idx + 7'd1;
              state <= SEQ_LOAD;
            end
          end else begin
            state <= SEQ_WAIT;
          end
        end
        SEQ_FINISH: begin
          // Ready here means the final stop bit is in its last cycle.
          if (tx_ready) begin
            idx   <= 7'd0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= SEQ_IDLE;
          end
        end
        default: state <= SEQ_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mw_status_tx.sv
// ------------------------------------------------------------------------------------------
// tb_mw_status_tx: scoreboard bench; decodes the UART line and checks timing and handshakes.
// Rev 1.0
// ------------------------------------------------------------------------------------------
`default_nettype none

module tb_mw_status_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        trigger = 1'b0;
  logic [63:0] L = 64'd0, I = 64'd0, A = 64'd0, S = 64'd0, Ak = 64'd0;
  logic        ZF = 1'b0, ZAK = 1'b0;
  logic        uart_tx, busy, done, overrun;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int ovr_cnt = 0;

  logic [7:0] exp_q [$];
  logic [8:0] rx_q [$];
  int         start_q [$];

  mw_status_tx #(
    .CLK_HZ(16),
    .BIT_RATE(4),
    .HEX_DIGITS(4)
  ) dut (
    .clk(clk), .reset(reset), .trigger(trigger),
    .L(L), .I(I), .A(A), .S(S), .Ak(Ak), .ZF(ZF), .ZAK(ZAK),
    .uart_tx(uart_tx), .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (overrun === 1'b1) ovr_cnt <= ovr_cnt + 1;
  end

  // Mid-bit UART decoder, 4 clocks per bit; pushes {stop_bit, byte}.
  initial begin
    logic [7:0] b;
    logic       sb;
    forever begin
      @(negedge clk);
      if (uart_tx === 1'b0 && reset === 1'b0) begin
        start_q.push_back(cyc);
        repeat (2) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
          repeat (4) @(negedge clk);
          b[k] = uart_tx;
        end
        repeat (4) @(negedge clk);
        sb = uart_tx;
        rx_q.push_back({sb, b});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d want < 200000", cyc);
    $fatal(1, "watchdog");
  end

  task automatic set_default_regs();
    L = 64'h12; I = 64'hABCD; A = 64'h0; S = 64'hFFFF; Ak = 64'hA5; ZF = 1'b1; ZAK = 1'b0;
  endtask

  task automatic push_line(input string line);
    for (int k = 0; k < line.len(); k++) exp_q.push_back(line[k]);
  endtask

  task automatic pulse_trigger(output int t);
    @(posedge clk); #1;
    t = cyc;
    trigger = 1'b1;
    @(posedge clk); #1;
    trigger = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int dcyc, output bit got);
    got = 1'b0;
    dcyc = 0;
    for (int k = 0; k < budget && !got; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        got = 1'b1;
        dcyc = cyc;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({uart_tx, busy, done, overrun} !== 4'b1000) begin
      n_bad++;
      $display("FAIL reset_outputs got tx/busy/done/ovr=%b want 1000", {uart_tx, busy, done, overrun});
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({uart_tx, busy, done, overrun} !== 4'b1000) begin
      n_bad++;
      $display("FAIL post_reset_idle got tx/busy/done/ovr=%b want 1000", {uart_tx, busy, done, overrun});
    end
  endtask

  task automatic test_full_line();
    int t, d;
    bit got;
    logic [9:0] pat;
    logic [7:0] e;
    logic [8:0] r;
    pat = 10'b1001100000;
    set_default_regs();
    rx_q.delete(); start_q.delete(); exp_q.delete();
    push_line("0012 ABCD 0000 FFFF 00A5 10\r\n");
    pulse_trigger(t);
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || uart_tx !== 1'b1) begin
      n_bad++;
      $display("FAIL cycle_t1 got busy=%b tx=%b want busy=1 tx=1", busy, uart_tx);
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      n_cmp++;
      if (uart_tx !== pat[k/4]) begin
        n_bad++;
        $display("FAIL bit_timing cycle t+%0d got %b want %b", k + 2, uart_tx, pat[k/4]);
      end
    end
    wait_done(1300, d, got);
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL full_done got no done want done within 1300 cycles");
    end else if (start_q.size() == 0 || d - start_q[0] != 1160) begin
      n_bad++;
      $display("FAIL full_latency got %0d want 1160", (start_q.size() == 0) ? -1 : d - start_q[0]);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL busy_at_done got %b want 0", busy);
    end
    n_cmp++;
    if (rx_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL full_len got %0d want %0d", rx_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      r = 9'h000;
      if (rx_q.size() > 0) r = rx_q.pop_front();
      n_cmp++;
      if (r !== {1'b1, e}) begin
        n_bad++;
        $display("FAIL full_char got %h want %h", r, {1'b1, e});
      end
    end
    // Trigger during the done cycle must be dropped with an overrun pulse.
    trigger = 1'b1;
    @(posedge clk); #1;
    trigger = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (overrun !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL done_cycle_trigger got ovr=%b busy=%b want ovr=1 busy=0", overrun, busy);
    end
    got = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || busy !== 1'b0) got = 1'b0;
    end
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL done_cycle_quiet got activity want idle line");
    end
  endtask

  task automatic test_snapshot();
    int t, d;
    bit got;
    logic [7:0] e;
    logic [8:0] r;
    set_default_regs();
    rx_q.delete(); start_q.delete(); exp_q.delete();
    push_line("0012 ABCD 0000 FFFF 00A5 10\r\n");
    pulse_trigger(t);
    L = 64'h5555; I = 64'h5555; A = 64'h5555; S = 64'h5555; Ak = 64'h5555; ZF = 1'b0; ZAK = 1'b1;
    wait_done(1300, d, got);
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL snap_done got no done want done within 1300 cycles");
    end
    n_cmp++;
    if (rx_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL snap_len got %0d want %0d", rx_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      r = 9'h000;
      if (rx_q.size() > 0) r = rx_q.pop_front();
      n_cmp++;
      if (r !== {1'b1, e}) begin
        n_bad++;
        $display("FAIL snap_char got %h want %h", r, {1'b1, e});
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_overrun();
    int t, d, done0, ovr0;
    bit got;
    logic [7:0] e;
    logic [8:0] r;
    set_default_regs();
    rx_q.delete(); start_q.delete(); exp_q.delete();
    push_line("0012 ABCD 0000 FFFF 00A5 10\r\n");
    @(negedge clk);
    done0 = done_cnt;
    ovr0 = ovr_cnt;
    pulse_trigger(t);
    repeat (99) begin @(posedge clk); #1; end
    trigger = 1'b1;
    @(posedge clk); #1;
    trigger = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (overrun !== 1'b1 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL overrun_pulse got ovr=%b busy=%b want ovr=1 busy=1", overrun, busy);
    end
    wait_done(1300, d, got);
    repeat (5) @(negedge clk);
    n_cmp++;
    if (done_cnt - done0 != 1 || ovr_cnt - ovr0 != 1) begin
      n_bad++;
      $display("FAIL overrun_counts got done=%0d ovr=%0d want done=1 ovr=1", done_cnt - done0, ovr_cnt - ovr0);
    end
    n_cmp++;
    if (rx_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL ovr_len got %0d want %0d", rx_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      r = 9'h000;
      if (rx_q.size() > 0) r = rx_q.pop_front();
      n_cmp++;
      if (r !== {1'b1, e}) begin
        n_bad++;
        $display("FAIL ovr_char got %h want %h", r, {1'b1, e});
      end
    end
  endtask

  task automatic test_reset_mid_line();
    int t, d, done0;
    bit got;
    logic [7:0] e;
    logic [8:0] r;
    set_default_regs();
    rx_q.delete(); start_q.delete(); exp_q.delete();
    @(negedge clk);
    done0 = done_cnt;
    pulse_trigger(t);
    // Character 7 starts 280 cycles after the first start bit; 300 lands mid data bit.
    for (int k = 0; k < 400 && cyc < t + 302; k++) begin @(posedge clk); #1; end
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_reset_busy got %b want 1", busy);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (uart_tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset got tx=%b busy=%b done=%b want tx=1 busy=0 done=0", uart_tx, busy, done);
    end
    repeat (60) @(negedge clk);
    n_cmp++;
    if (done_cnt != done0) begin
      n_bad++;
      $display("FAIL mid_reset_done got %0d pulses want 0", done_cnt - done0);
    end
    rx_q.delete(); start_q.delete();
    push_line("0012 ABCD 0000 FFFF 00A5 10\r\n");
    pulse_trigger(t);
    wait_done(1300, d, got);
    n_cmp++;
    if (!got || start_q.size() == 0 || d - start_q[0] != 1160) begin
      n_bad++;
      $display("FAIL retrigger_done got done=%b latency=%0d want done=1 latency=1160",
               got, (start_q.size() == 0) ? -1 : d - start_q[0]);
    end
    n_cmp++;
    if (rx_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL retrig_len got %0d want %0d", rx_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      r = 9'h000;
      if (rx_q.size() > 0) r = rx_q.pop_front();
      n_cmp++;
      if (r !== {1'b1, e}) begin
        n_bad++;
        $display("FAIL retrig_char got %h want %h", r, {1'b1, e});
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_line();
    test_snapshot();
    test_overrun();
    test_reset_mid_line();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
